// File: rtl/rice_core_pkg.sv
// Shared rice core types: ALU command/source selects, branch operations and
// the execute-stage output buffer states.
package rice_core_pkg;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } rice_core_alu_command;

  typedef enum logic [1:0] {
    ALU_SRC1_RS1, ALU_SRC1_PC, ALU_SRC1_ZERO
  } rice_core_alu_source1;

  typedef enum logic [1:0] {
    ALU_SRC2_RS2, ALU_SRC2_IMM, ALU_SRC2_IMM_4
  } rice_core_alu_source2;

  typedef struct packed {
    rice_core_alu_command command;
    rice_core_alu_source1 source1;
    rice_core_alu_source2 source2;
  } rice_core_alu_operation;

  typedef enum logic [3:0] {
    BRANCH_NONE, BRANCH_JAL, BRANCH_JALR, BRANCH_BEQ, BRANCH_BNE,
    BRANCH_BLT, BRANCH_BGE, BRANCH_BLTU, BRANCH_BGEU
  } rice_core_branch_operation;

  typedef enum logic [1:0] {
    BUF_EMPTY, BUF_ONE, BUF_FULL
  } rice_core_buffer_state;

endpackage

// File: rtl/rice_core_execute_stage_if.sv
// Decode-to-execute-to-writeback bus of the execute stage.
// master = decode/writeback side, slave = the execute stage.
interface rice_core_execute_stage_if #(parameter int XLEN = 32);
  import rice_core_pkg::*;

  logic                      i_valid;
  logic                      o_ready;
  logic [XLEN-1:0]           i_pc;
  logic [XLEN-1:0]           i_rs1_value;
  logic [XLEN-1:0]           i_rs2_value;
  logic [XLEN-1:0]           i_imm_value;
  rice_core_alu_operation    i_alu_operation;
  rice_core_branch_operation i_branch_operation;
  logic [4:0]                i_rd;
  logic                      i_flush;
  logic                      o_valid;
  logic                      i_ready;
  logic [XLEN-1:0]           o_result;
  logic [4:0]                o_rd;
  logic                      o_redirect;
  logic [XLEN-1:0]           o_redirect_pc;

  modport master (
    output i_valid, i_pc, i_rs1_value, i_rs2_value, i_imm_value,
           i_alu_operation, i_branch_operation, i_rd, i_flush, i_ready,
    input  o_ready, o_valid, o_result, o_rd, o_redirect, o_redirect_pc
  );

  modport slave (
    input  i_valid, i_pc, i_rs1_value, i_rs2_value, i_imm_value,
           i_alu_operation, i_branch_operation, i_rd, i_flush, i_ready,
    output o_ready, o_valid, o_result, o_rd, o_redirect, o_redirect_pc
  );

endinterface

// File: rtl/rice_core_alu.sv
// Core ALU: operand source muxing followed by the integer operation.
module rice_core_alu
  import rice_core_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]        i_pc,
  input  logic [XLEN-1:0]        i_rs1_value,
  input  logic [XLEN-1:0]        i_rs2_value,
  input  logic [XLEN-1:0]        i_imm_value,
  input  rice_core_alu_operation i_operation,
  output logic [XLEN-1:0]        o_result
);
  localparam int SHW = $clog2(XLEN);

  logic [XLEN-1:0] w_a;
  logic [XLEN-1:0] w_b;
  logic [SHW-1:0]  w_shamt;

  always_comb begin
    w_a = '0;
    case (i_operation.source1)
      ALU_SRC1_RS1: w_a = i_rs1_value;
      ALU_SRC1_PC:  w_a = i_pc;
      default:      w_a = '0;
    endcase
  end

  always_comb begin
    w_b = '0;
    case (i_operation.source2)
      ALU_SRC2_RS2:   w_b = i_rs2_value;
      ALU_SRC2_IMM:   w_b = i_imm_value;
      ALU_SRC2_IMM_4: w_b = XLEN'(4);
      default:        w_b = '0;
    endcase
  end

  assign w_shamt = w_b[SHW-1:0];

  always_comb begin
    o_result = '0;
    case (i_operation.command)
      ALU_ADD:  o_result = w_a + w_b;
      ALU_SUB:  o_result = w_a - w_b;
      ALU_SLL:  o_result = w_a << w_shamt;
      ALU_SLT:  o_result = XLEN'($signed(w_a) < $signed(w_b));
      ALU_SLTU: o_result = XLEN'(w_a < w_b);
      ALU_XOR:  o_result = w_a ^ w_b;
      ALU_SRL:  o_result = w_a >> w_shamt;
      ALU_SRA:  o_result = $unsigned($signed(w_a) >>> w_shamt);
      ALU_OR:   o_result = w_a | w_b;
      ALU_AND:  o_result = w_a & w_b;
      default:  o_result = '0;
    endcase
  end

endmodule

// File: rtl/rice_core_branch_unit.sv
// Branch resolution: operand compare and redirect target, purely combinational.
module rice_core_branch_unit
  import rice_core_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]          i_pc,
  input  logic [XLEN-1:0]          i_rs1_value,
  input  logic [XLEN-1:0]          i_rs2_value,
  input  logic [XLEN-1:0]          i_imm_value,
  input  rice_core_branch_operation i_operation,
  output logic                     o_taken,
  output logic [XLEN-1:0]          o_target
);
  localparam logic [XLEN-1:0] LSB_MASK = ~{{(XLEN-1){1'b0}}, 1'b1};

  logic w_eq;
  logic w_lt;
  logic w_ltu;

  assign w_eq  = (i_rs1_value == i_rs2_value);
  // One extra sign bit lets a single signed compare cover the full range.
  assign w_lt  = $signed({i_rs1_value[XLEN-1], i_rs1_value}) <
                 $signed({i_rs2_value[XLEN-1], i_rs2_value});
  assign w_ltu = (i_rs1_value < i_rs2_value);

  always_comb begin
    o_taken = 1'b0;
    case (i_operation)
      BRANCH_JAL:  o_taken = 1'b1;
      BRANCH_JALR: o_taken = 1'b1;
      BRANCH_BEQ:  o_taken = w_eq;
      BRANCH_BNE:  o_taken = !w_eq;
      BRANCH_BLT:  o_taken = w_lt;
      BRANCH_BGE:  o_taken = !w_lt;
      BRANCH_BLTU: o_taken = w_ltu;
      BRANCH_BGEU: o_taken = !w_ltu;
      default:     o_taken = 1'b0;
    endcase
  end

  always_comb begin
    o_target = i_pc + i_imm_value;
    if (i_operation == BRANCH_JALR) o_target = (i_rs1_value + i_imm_value) & LSB_MASK;
  end

endmodule

// File: rtl/rice_core_execute_stage.sv
// Execute stage: ALU + branch resolution, results registered toward writeback
// through an output register backed by one skid entry.
module rice_core_execute_stage
  import rice_core_pkg::*;
#(
  parameter int XLEN = 32
) (
  input logic                        i_clk,
  input logic                        i_rst,
  rice_core_execute_stage_if.slave   bus
);
  typedef struct packed {
    logic [XLEN-1:0] result;
    logic [4:0]      rd;
  } entry_t;

  rice_core_buffer_state r_state;
  rice_core_buffer_state w_state_next;
  entry_t                r_out;
  entry_t                r_skid;
  entry_t                w_entry;
  logic                  r_ready;
  logic                  r_redirect;
  logic [XLEN-1:0]       r_redirect_pc;

  logic [XLEN-1:0]       w_alu_result;
  logic                  w_taken;
  logic [XLEN-1:0]       w_target;
  logic                  w_accept;
  logic                  w_keep;
  logic                  w_redirect_next;
  logic                  w_load_out;
  logic                  w_load_skid;
  logic                  w_skid_to_out;

  rice_core_alu #(.XLEN(XLEN)) u_alu (
    .i_pc        (bus.i_pc),
    .i_rs1_value (bus.i_rs1_value),
    .i_rs2_value (bus.i_rs2_value),
    .i_imm_value (bus.i_imm_value),
    .i_operation (bus.i_alu_operation),
    .o_result    (w_alu_result)
  );

  rice_core_branch_unit #(.XLEN(XLEN)) u_branch (
    .i_pc        (bus.i_pc),
    .i_rs1_value (bus.i_rs1_value),
    .i_rs2_value (bus.i_rs2_value),
    .i_imm_value (bus.i_imm_value),
    .i_operation (bus.i_branch_operation),
    .o_taken     (w_taken),
    .o_target    (w_target)
  );

  assign w_entry  = '{result: w_alu_result, rd: bus.i_rd};
  assign w_accept = bus.i_valid && bus.o_ready;
  // The slot right after a redirect is wrong-path: consume it, keep nothing.
  assign w_keep   = w_accept && !r_redirect;
  assign w_redirect_next = !bus.i_flush && w_keep && w_taken;

  always_comb begin
    w_state_next  = r_state;
    w_load_out    = 1'b0;
    w_load_skid   = 1'b0;
    w_skid_to_out = 1'b0;
    if (bus.i_flush) begin
      w_state_next = BUF_EMPTY;
    end else begin
      case (r_state)
        BUF_EMPTY: begin
          if (w_keep) begin
            w_state_next = BUF_ONE;
            w_load_out   = 1'b1;
          end
        end
        BUF_ONE: begin
          if (w_keep && bus.i_ready) begin
            w_load_out = 1'b1;
          end else if (w_keep) begin
            w_state_next = BUF_FULL;
            w_load_skid  = 1'b1;
          end else if (bus.i_ready) begin
            w_state_next = BUF_EMPTY;
          end
        end
        BUF_FULL: begin
          if (bus.i_ready) begin
            w_state_next  = BUF_ONE;
            w_skid_to_out = 1'b1;
          end
        end
        default: w_state_next = BUF_EMPTY;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= BUF_EMPTY;
      r_out         <= '0;
      r_skid        <= '0;
      r_ready       <= 1'b1;
      r_redirect    <= 1'b0;
      r_redirect_pc <= '0;
    end else begin
      r_state    <= w_state_next;
      r_ready    <= (w_state_next != BUF_FULL);
      r_redirect <= w_redirect_next;
      if (w_load_out)         r_out <= w_entry;
      else if (w_skid_to_out) r_out <= r_skid;
      if (w_load_skid)        r_skid <= w_entry;
      if (w_redirect_next)    r_redirect_pc <= w_target;
    end
  end

  assign bus.o_ready       = r_ready && !i_rst;
  assign bus.o_valid       = (r_state != BUF_EMPTY);
  assign bus.o_result      = r_out.result;
  assign bus.o_rd          = r_out.rd;
  assign bus.o_redirect    = r_redirect;
  assign bus.o_redirect_pc = r_redirect_pc;

endmodule

// File: tb/tb_rice_core_execute_stage.sv
// Self-checking bench for rice_core_execute_stage: directed scenarios plus a
// randomized run against a queue-based behavioural model.
module tb_rice_core_execute_stage;
  import rice_core_pkg::*;

  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rice_core_execute_stage_if #(.XLEN(XLEN)) bus();

  rice_core_execute_stage #(.XLEN(XLEN)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
  } exp_t;

  exp_t        mq[$];
  bit          m_redir = 1'b0;
  logic [31:0] m_rpc   = '0;

  function automatic logic [31:0] ref_alu(input logic [31:0] pc, rs1, rs2, imm,
                                          input rice_core_alu_operation op);
    logic [31:0] a, b;
    a = (op.source1 == ALU_SRC1_RS1) ? rs1 : (op.source1 == ALU_SRC1_PC) ? pc : 32'd0;
    b = (op.source2 == ALU_SRC2_RS2) ? rs2 : (op.source2 == ALU_SRC2_IMM) ? imm :
        (op.source2 == ALU_SRC2_IMM_4) ? 32'd4 : 32'd0;
    case (op.command)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_SLL:  return a << b[4:0];
      ALU_SLT:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
      ALU_XOR:  return a ^ b;
      ALU_SRL:  return a >> b[4:0];
      ALU_SRA:  return 32'(int'(a) >>> b[4:0]);
      ALU_OR:   return a | b;
      ALU_AND:  return a & b;
      default:  return 32'd0;
    endcase
  endfunction

  task automatic ref_branch(input rice_core_branch_operation op,
                            input logic [31:0] pc, rs1, rs2, imm,
                            output bit taken, output logic [31:0] target);
    logic [31:0] sum;
    taken  = 1'b0;
    target = pc + imm;
    case (op)
      BRANCH_JAL:  taken = 1'b1;
      BRANCH_JALR: begin
        taken  = 1'b1;
        sum    = rs1 + imm;
        target = sum - (sum % 2);
      end
      BRANCH_BEQ:  taken = (rs1 == rs2);
      BRANCH_BNE:  taken = (rs1 != rs2);
      BRANCH_BLT:  taken = (int'(rs1) < int'(rs2));
      BRANCH_BGE:  taken = (int'(rs1) >= int'(rs2));
      BRANCH_BLTU: taken = (rs1 < rs2);
      BRANCH_BGEU: taken = (rs1 >= rs2);
      default:     taken = 1'b0;
    endcase
  endtask

  task automatic drive(input bit v, input rice_core_alu_command c,
                       input rice_core_alu_source1 s1, input rice_core_alu_source2 s2,
                       input rice_core_branch_operation br,
                       input logic [31:0] pc, rs1, rs2, imm, input logic [4:0] rd);
    bus.i_valid                  = v;
    bus.i_alu_operation.command  = c;
    bus.i_alu_operation.source1  = s1;
    bus.i_alu_operation.source2  = s2;
    bus.i_branch_operation       = br;
    bus.i_pc                     = pc;
    bus.i_rs1_value              = rs1;
    bus.i_rs2_value              = rs2;
    bus.i_imm_value              = imm;
    bus.i_rd                     = rd;
  endtask

  task automatic drive_add(input logic [31:0] a, b, input logic [4:0] rd);
    drive(1'b1, ALU_ADD, ALU_SRC1_RS1, ALU_SRC2_RS2, BRANCH_NONE, 32'h0, a, b, 32'h0, rd);
  endtask

  // Advance one clock; the model sees the same inputs as the DUT at the edge.
  task automatic tick();
    bit          acc, kept, taken;
    logic [31:0] tgt, res;
    exp_t        e;
    acc = bus.i_valid && !rst && (mq.size() < 2);
    res = ref_alu(bus.i_pc, bus.i_rs1_value, bus.i_rs2_value, bus.i_imm_value, bus.i_alu_operation);
    ref_branch(bus.i_branch_operation, bus.i_pc, bus.i_rs1_value, bus.i_rs2_value,
               bus.i_imm_value, taken, tgt);
    if (rst || bus.i_flush) begin
      mq.delete();
      m_redir = 1'b0;
    end else begin
      kept = acc && !m_redir;
      if (mq.size() > 0 && bus.i_ready) void'(mq.pop_front());
      if (kept) begin
        e.res = res;
        e.rd  = bus.i_rd;
        mq.push_back(e);
      end
      m_redir = kept && taken;
      if (m_redir) m_rpc = tgt;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.i_valid = 1'b0;
  endtask

  task automatic drain();
    idle();
    bus.i_flush = 1'b0;
    bus.i_ready = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    bus.i_flush = 1'b0;
    bus.i_ready = 1'b1;
    tick();
    tick();
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.o_valid); end
    checks++; if (bus.o_redirect !== 1'b0) begin errors++; $display("FAIL reset_redirect: got %b expected 0", bus.o_redirect); end
    checks++; if (bus.o_result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h expected 0", bus.o_result); end
    checks++; if (bus.o_rd !== 5'h0) begin errors++; $display("FAIL reset_rd: got %h expected 0", bus.o_rd); end
    checks++; if (bus.o_redirect_pc !== 32'h0) begin errors++; $display("FAIL reset_redirect_pc: got %h expected 0", bus.o_redirect_pc); end
    checks++; if (bus.o_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_during: got %b expected 0", bus.o_ready); end
    rst = 1'b0;
    tick();
    checks++; if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after: got %b expected 1", bus.o_ready); end
  endtask

  task automatic test_add();
    bus.i_ready = 1'b1;
    drive_add(32'd5, 32'd7, 5'd9);
    tick();
    idle();
    checks++; if (bus.o_valid !== 1'b1) begin errors++; $display("FAIL add_valid: got %b expected 1", bus.o_valid); end
    checks++; if (bus.o_result !== 32'd12) begin errors++; $display("FAIL add_result: got %0d expected 12", bus.o_result); end
    checks++; if (bus.o_rd !== 5'd9) begin errors++; $display("FAIL add_rd: got %0d expected 9", bus.o_rd); end
    checks++; if (bus.o_redirect !== 1'b0) begin errors++; $display("FAIL add_redirect: got %b expected 0", bus.o_redirect); end
    tick();
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL add_drained: got %b expected 0", bus.o_valid); end
  endtask

  task automatic test_branch();
    bus.i_ready = 1'b1;
    drive(1'b1, ALU_ADD, ALU_SRC1_RS1, ALU_SRC2_RS2, BRANCH_BLT, 32'h100, 32'hFFFF_FFFF, 32'h1, 32'h20, 5'd0);
    tick();
    idle();
    checks++; if (bus.o_redirect !== 1'b1) begin errors++; $display("FAIL blt_redirect: got %b expected 1", bus.o_redirect); end
    checks++; if (bus.o_redirect_pc !== 32'h120) begin errors++; $display("FAIL blt_target: got %h expected 120", bus.o_redirect_pc); end
    tick();
    checks++; if (bus.o_redirect !== 1'b0) begin errors++; $display("FAIL blt_pulse: got %b expected 0", bus.o_redirect); end
    drive(1'b1, ALU_ADD, ALU_SRC1_RS1, ALU_SRC2_RS2, BRANCH_BLTU, 32'h100, 32'hFFFF_FFFF, 32'h1, 32'h20, 5'd0);
    tick();
    idle();
    checks++; if (bus.o_redirect !== 1'b0) begin errors++; $display("FAIL bltu_redirect: got %b expected 0", bus.o_redirect); end
    drain();
  endtask

  task automatic test_jalr();
    bus.i_ready = 1'b1;
    drive(1'b1, ALU_ADD, ALU_SRC1_PC, ALU_SRC2_IMM_4, BRANCH_JALR, 32'h40, 32'h1003, 32'h0, 32'h0, 5'd1);
    tick();
    idle();
    checks++; if (bus.o_redirect !== 1'b1) begin errors++; $display("FAIL jalr_redirect: got %b expected 1", bus.o_redirect); end
    checks++; if (bus.o_redirect_pc !== 32'h1002) begin errors++; $display("FAIL jalr_target: got %h expected 1002", bus.o_redirect_pc); end
    checks++; if (bus.o_result !== 32'h44) begin errors++; $display("FAIL jalr_link: got %h expected 44", bus.o_result); end
    drain();
  endtask

  task automatic test_back_to_back();
    bus.i_ready = 1'b0;
    drive_add(32'd1, 32'd2, 5'd1);
    tick();
    drive_add(32'd10, 32'd20, 5'd2);
    tick();
    idle();
    checks++; if (bus.o_ready !== 1'b0) begin errors++; $display("FAIL b2b_full_ready: got %b expected 0", bus.o_ready); end
    checks++; if (bus.o_result !== 32'd3) begin errors++; $display("FAIL b2b_first: got %0d expected 3", bus.o_result); end
    tick();
    checks++; if (bus.o_result !== 32'd3 || bus.o_valid !== 1'b1) begin errors++; $display("FAIL b2b_hold: got %0d/%b expected 3/1", bus.o_result, bus.o_valid); end
    bus.i_ready = 1'b1;
    tick();
    checks++; if (bus.o_result !== 32'd30 || bus.o_rd !== 5'd2) begin errors++; $display("FAIL b2b_second: got %0d rd %0d expected 30 rd 2", bus.o_result, bus.o_rd); end
    checks++; if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_back: got %b expected 1", bus.o_ready); end
    tick();
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL b2b_no_dup: got %b expected 0", bus.o_valid); end
  endtask

  task automatic test_jal_drop();
    bus.i_ready = 1'b1;
    drive(1'b1, ALU_ADD, ALU_SRC1_PC, ALU_SRC2_IMM_4, BRANCH_JAL, 32'h200, 32'h0, 32'h0, 32'h10, 5'd1);
    tick();
    drive_add(32'd3, 32'd4, 5'd5);
    checks++; if (bus.o_redirect !== 1'b1 || bus.o_redirect_pc !== 32'h210) begin errors++; $display("FAIL jal_redirect: got %b/%h expected 1/210", bus.o_redirect, bus.o_redirect_pc); end
    checks++; if (bus.o_result !== 32'h204) begin errors++; $display("FAIL jal_link: got %h expected 204", bus.o_result); end
    checks++; if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL jal_drop_handshake: got %b expected 1", bus.o_ready); end
    tick();
    idle();
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL jal_drop_valid: got %b expected 0", bus.o_valid); end
    checks++; if (bus.o_redirect !== 1'b0) begin errors++; $display("FAIL jal_drop_redirect: got %b expected 0", bus.o_redirect); end
  endtask

  task automatic test_flush();
    bus.i_ready = 1'b0;
    drive_add(32'd1, 32'd1, 5'd1);
    tick();
    drive_add(32'd2, 32'd2, 5'd2);
    tick();
    idle();
    bus.i_flush = 1'b1;
    tick();
    bus.i_flush = 1'b0;
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b expected 0", bus.o_valid); end
    checks++; if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b expected 1", bus.o_ready); end
    bus.i_ready = 1'b1;
    drive_add(32'd8, 32'd8, 5'd3);
    bus.i_flush = 1'b1;
    tick();
    idle();
    bus.i_flush = 1'b0;
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL flush_same_cycle: got %b expected 0", bus.o_valid); end
  endtask

  task automatic test_reset_mid();
    bus.i_ready = 1'b0;
    drive_add(32'd1, 32'd1, 5'd1);
    tick();
    drive_add(32'd2, 32'd2, 5'd2);
    tick();
    idle();
    rst = 1'b1;
    tick();
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b expected 0", bus.o_valid); end
    rst = 1'b0;
    tick();
    checks++; if (bus.o_ready !== 1'b1 || bus.o_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_after: got ready %b valid %b expected 1/0", bus.o_ready, bus.o_valid); end
  endtask

  task automatic test_random();
    logic [31:0] r1;
    drain();
    for (int n = 0; n < 3000; n++) begin
      r1 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      drive($urandom_range(0, 3) != 0,
            rice_core_alu_command'($urandom_range(0, 9)),
            rice_core_alu_source1'($urandom_range(0, 2)),
            rice_core_alu_source2'($urandom_range(0, 2)),
            rice_core_branch_operation'($urandom_range(0, 8)),
            $urandom, r1, ($urandom_range(0, 2) == 0) ? r1 : $urandom,
            $urandom, 5'($urandom_range(0, 31)));
      bus.i_ready = ($urandom_range(0, 2) != 0);
      bus.i_flush = ($urandom_range(0, 31) == 0);
      tick();
      checks++; if (bus.o_valid !== (mq.size() > 0)) begin errors++; $display("FAIL rnd_valid @%0d: got %b expected %b", n, bus.o_valid, mq.size() > 0); end
      checks++; if (bus.o_ready !== (mq.size() < 2)) begin errors++; $display("FAIL rnd_ready @%0d: got %b expected %b", n, bus.o_ready, mq.size() < 2); end
      checks++; if (bus.o_redirect !== m_redir) begin errors++; $display("FAIL rnd_redirect @%0d: got %b expected %b", n, bus.o_redirect, m_redir); end
      if (mq.size() > 0) begin
        checks++; if (bus.o_result !== mq[0].res || bus.o_rd !== mq[0].rd) begin errors++; $display("FAIL rnd_data @%0d: got %h rd %0d expected %h rd %0d", n, bus.o_result, bus.o_rd, mq[0].res, mq[0].rd); end
      end
      if (m_redir) begin
        checks++; if (bus.o_redirect_pc !== m_rpc) begin errors++; $display("FAIL rnd_target @%0d: got %h expected %h", n, bus.o_redirect_pc, m_rpc); end
      end
    end
    bus.i_flush = 1'b0;
  endtask

  initial begin
    drive(1'b0, ALU_ADD, ALU_SRC1_RS1, ALU_SRC2_RS2, BRANCH_NONE, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0);
    bus.i_flush = 1'b0;
    bus.i_ready = 1'b1;
    test_reset();
    test_add();
    test_branch();
    test_jalr();
    test_back_to_back();
    test_jal_drop();
    test_flush();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rice_core_execute_stage.md
# rice_core_execute_stage

Execute pipeline stage of the rice core, between decode and writeback. It accepts one decoded instruction per cycle over a valid/ready handshake. It runs the instruction through the core ALU and resolves branches and jumps. It registers the result toward writeback behind a two-entry (output + skid) buffer, so that `o_ready` never depends combinationally on `i_ready`.

## Interface
- `XLEN`, 32: data/address width; 32 or 64.

- `i_clk` input 1: clock.
- `i_rst` input 1: reset. One clock; reset is synchronous and active-high.
- `i_valid` input 1: decode holds an instruction.
- `o_ready` output 1: stage can accept.
- `i_pc` input XLEN: instruction PC.
- `i_rs1_value`, `i_rs2_value`, `i_imm_value` input XLEN: operands.
- `i_alu_operation` input `rice_core_alu_operation`: ALU command and sources.
- `i_branch_operation` input `rice_core_branch_operation`: `NONE`/`JAL`/`JALR`/`BEQ`/`BNE`/`BLT`/`BGE`/`BLTU`/`BGEU`.
- `i_rd` input 5: destination register index.
- `i_flush` input 1: trap/pipeline flush.
- `o_valid` output 1: result available to writeback.
- `i_ready` input 1: writeback accepts.
- `o_result` output XLEN: ALU result.
- `o_rd` output 5: destination index.
- `o_redirect` output 1: taken branch/jump, one-cycle pulse.
- `o_redirect_pc` output XLEN: redirect target.

## Operation
- Accept when `i_valid && o_ready` at a rising edge.
- ALU result = `rice_core_alu(i_pc, i_rs1_value, i_rs2_value, i_imm_value, i_alu_operation)`. For `JAL`/`JALR`, decode selects PC + `IMM_4`, so the link value comes out of the ALU unchanged.
- Branch compare uses `i_rs1_value` and `i_rs2_value` directly:
  - EQ/NE: equality.
  - LT/GE: signed compare on an XLEN+1 sign-extension.
  - LTU/GEU: unsigned compare.
- Taken = `JAL` | `JALR` | (conditional branch && compare true).
- Target:
  - `JAL` and branches: `i_pc + i_imm_value`, modulo 2^XLEN.
  - `JALR`: `(i_rs1_value + i_imm_value) & ~1`.
  - No alignment check; misaligned fetch is handled by fetch.
- Buffer states (output valid O, skid valid S):
  - EMPTY (O=0, S=0): accept loads O.
  - ONE (O=1, S=0):
    - accept & `i_ready` replaces O;
    - accept & !`i_ready` loads S;
    - `i_ready` only goes to EMPTY.
  - FULL (O=1, S=1): `o_ready` = 0. `i_ready` moves S into O and goes to ONE.
- `o_ready` = !S, registered. It is forced 0 while `i_rst` is high.
- Wrong-path drop: an instruction presented while `o_redirect` = 1 is consumed (handshake completes) but discarded. It produces no result and no redirect.
- `i_flush`: at the next edge, O, S and `o_redirect` clear. Any instruction accepted in the same cycle is discarded. `i_flush` takes priority over a simultaneous accept, redirect or drain.

## Timing
- Latency 1: accepted at edge N gives `o_valid`/`o_result` and, if taken, `o_redirect` after edge N.
- `o_redirect` is high exactly one cycle and is independent of `i_ready` back-pressure.
- `o_redirect_pc` is valid only while `o_redirect` = 1.
- Output is held stable while `o_valid && !i_ready`.
- Reset values: `o_valid` 0, `o_redirect` 0, `o_result`/`o_rd`/`o_redirect_pc` 0, `o_ready` 0 during reset and 1 the cycle after.
- Reset asserted mid-operation discards O and S contents.

## Structure
- `rice_core_pkg` gains the `rice_core_branch_operation` enum. The existing ALU typedefs are reused.
- Sub-modules:
  - one instance of `rice_core_alu`;
  - a small `rice_core_branch_unit` (combinational compare + target) is natural.
- Estimated size: 200–300 RTL lines.

## Test plan
- ADD, rs1 = 5, rs2 = 7, `i_ready` = 1 → next cycle `o_valid` = 1, `o_result` = 12, `o_rd` as sent, no redirect.
- BLT, rs1 = 0xFFFF_FFFF, rs2 = 1, pc = 0x100, imm = 0x20 → `o_redirect` = 1 for one cycle, `o_redirect_pc` = 0x120. BLTU with the same operands → no redirect.
- JALR, rs1 = 0x1003, imm = 0, pc = 0x40 → `o_redirect_pc` = 0x1002, `o_result` = 0x44.
- Back-to-back ADDs with `i_ready` = 0 → second goes to skid, `o_ready` = 0 next cycle. Raising `i_ready` drains both in order with no loss or duplication.
- Taken JAL followed immediately by ADD → ADD handshake completes, but no `o_valid` is produced for it.
- FULL state, assert `i_flush` → next cycle `o_valid` = 0, `o_ready` = 1. Reset mid-stream gives the same result.
